// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared definitions for the PE sequencer slice.
//   - default widths for operands, accumulator and length field
//   - default PE pipeline latency
//   - sequencer state enumeration
package pe_ctrl_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int ACC_W_DEF      = 32;
    localparam int LEN_W_DEF      = 16;
    localparam int PE_LATENCY_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_OUTPUT
    } state_e;

endpackage

// File: rtl/pe_sequencer_if.sv
// pe_sequencer_if: bundle of the sequencer's command, operand, PE and result
// signals, so an environment can hold them as one object and bind them to the
// sequencer's flat ports.
//   master : the sequencer's view (drives operand_ready, PE controls, result)
//   slave  : the environment's view (drives command, operands, PE feedback,
//            result_ready)
interface pe_sequencer_if
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) ();

    // command
    logic              start;
    logic [LEN_W-1:0]  length;
    logic              busy;
    // operand stream
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              operand_valid;
    logic              operand_ready;
    // PE side
    logic [DATA_W-1:0] pe_a;
    logic [DATA_W-1:0] pe_b;
    logic              pe_enable;
    logic              pe_clear;
    logic [ACC_W-1:0]  pe_result;
    logic              pe_overflow;
    // result stream
    logic [ACC_W-1:0]  result;
    logic              overflow;
    logic              result_valid;
    logic              result_ready;

    modport master (
        input  start, length, a_data, b_data, operand_valid,
               pe_result, pe_overflow, result_ready,
        output busy, operand_ready, pe_a, pe_b, pe_enable, pe_clear,
               result, overflow, result_valid
    );

    modport slave (
        output start, length, a_data, b_data, operand_valid,
               pe_result, pe_overflow, result_ready,
        input  busy, operand_ready, pe_a, pe_b, pe_enable, pe_clear,
               result, overflow, result_valid
    );

endinterface

// File: rtl/pe_sequencer.sv
// pe_sequencer: drives one processing-element MAC through a dot product.
//   A command (i_start/i_length) clears the PE accumulator, streams i_length
//   operand pairs into the PE under valid/ready, waits out the PE latency, then
//   presents the captured result and sticky overflow on a valid/ready port.
// Ports:
//   clk, i_reset (sync, active-low)
//   i_start, i_length, o_busy                          command / status
//   i_a_data, i_b_data, i_operand_valid, o_operand_ready operand stream
//   o_pe_a, o_pe_b, o_pe_enable, o_pe_clear,
//   i_pe_result, i_pe_overflow                         PE connection
//   o_result, o_overflow, o_result_valid, i_result_ready result stream
module pe_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int PE_LATENCY = PE_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_length,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_operand_valid,
    output logic              o_operand_ready,
    output logic [DATA_W-1:0] o_pe_a,
    output logic [DATA_W-1:0] o_pe_b,
    output logic              o_pe_enable,
    output logic              o_pe_clear,
    input  logic [ACC_W-1:0]  i_pe_result,
    input  logic              i_pe_overflow,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_overflow,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic              o_busy
);

    // Drain counter runs 0..PE_LATENCY; sized so PE_LATENCY=0 still works.
    localparam int                DRAIN_W    = $clog2(PE_LATENCY + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_LATENCY);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               ovf_q, ovf_d;       // sticky overflow of the running op
    logic [DATA_W-1:0]  pe_a_q, pe_a_d;
    logic [DATA_W-1:0]  pe_b_q, pe_b_d;
    logic               pe_enable_q, pe_enable_d;
    logic               pe_clear_q, pe_clear_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               result_valid_q, result_valid_d;

    logic               operand_ready;
    logic               xfer;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        len_d          = len_q;
        count_d        = count_q;
        drain_d        = drain_q;
        ovf_d          = ovf_q;
        pe_a_d         = pe_a_q;
        pe_b_d         = pe_b_q;
        pe_enable_d    = 1'b0;   // enable and clear are single-cycle pulses
        pe_clear_d     = 1'b0;
        result_d       = result_q;
        overflow_d     = overflow_q;
        result_valid_d = result_valid_q;

        operand_ready  = (state_q == ST_RUN) && (count_q < len_q);
        xfer           = operand_ready && i_operand_valid;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    len_d      = i_length;
                    count_d    = '0;
                    drain_d    = '0;
                    ovf_d      = 1'b0;
                    pe_clear_d = 1'b1;   // registered: high during CLEAR
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = (len_q == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                ovf_d = ovf_q | i_pe_overflow;
                if (xfer) begin
                    pe_a_d      = i_a_data;
                    pe_b_d      = i_b_data;
                    pe_enable_d = 1'b1;
                    count_d     = count_q + LEN_W'(1);
                    if (count_q + LEN_W'(1) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                ovf_d = ovf_q | i_pe_overflow;
                if (drain_q == DRAIN_LAST) begin
                    // Capture cycle: PE output now reflects the last term.
                    drain_d        = '0;
                    result_d       = i_pe_result;
                    overflow_d     = ovf_q | i_pe_overflow;
                    result_valid_d = 1'b1;
                    state_d        = ST_OUTPUT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (i_result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the values from before this edge.
        if (!i_reset) begin
            // Data registers are reset too: every output must read 0 after reset.
            state_q        <= ST_IDLE;
            len_q          <= '0;
            count_q        <= '0;
            drain_q        <= '0;
            ovf_q          <= 1'b0;
            pe_a_q         <= '0;
            pe_b_q         <= '0;
            pe_enable_q    <= 1'b0;
            pe_clear_q     <= 1'b0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            count_q        <= count_d;
            drain_q        <= drain_d;
            ovf_q          <= ovf_d;
            pe_a_q         <= pe_a_d;
            pe_b_q         <= pe_b_d;
            pe_enable_q    <= pe_enable_d;
            pe_clear_q     <= pe_clear_d;
            result_q       <= result_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign o_operand_ready = operand_ready;
    assign o_pe_a          = pe_a_q;
    assign o_pe_b          = pe_b_q;
    assign o_pe_enable     = pe_enable_q;
    assign o_pe_clear      = pe_clear_q;
    assign o_result        = result_q;
    assign o_overflow      = overflow_q;
    assign o_result_valid  = result_valid_q;
    assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: self-checking bench for pe_sequencer with a behavioural PE
// (latency 1) and a scoreboard of expected dot-product results.
module tb_pe_sequencer;
    import pe_ctrl_pkg::*;

    logic clk;
    logic rst_n;

    pe_sequencer_if bus ();

    pe_sequencer dut (
        .clk             (clk),
        .i_reset         (rst_n),
        .i_start         (bus.start),
        .i_length        (bus.length),
        .i_a_data        (bus.a_data),
        .i_b_data        (bus.b_data),
        .i_operand_valid (bus.operand_valid),
        .o_operand_ready (bus.operand_ready),
        .o_pe_a          (bus.pe_a),
        .o_pe_b          (bus.pe_b),
        .o_pe_enable     (bus.pe_enable),
        .o_pe_clear      (bus.pe_clear),
        .i_pe_result     (bus.pe_result),
        .i_pe_overflow   (bus.pe_overflow),
        .o_result        (bus.result),
        .o_overflow      (bus.overflow),
        .o_result_valid  (bus.result_valid),
        .i_result_ready  (bus.result_ready),
        .o_busy          (bus.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE: one-cycle MAC; overflow pulses the cycle after the
    // ovf_term-th enabled term is sampled (0 = never).
    int pe_terms;
    int ovf_term;
    always_ff @(posedge clk) begin
        if (bus.pe_clear) begin
            bus.pe_result   <= '0;
            bus.pe_overflow <= 1'b0;
            pe_terms        <= 0;
        end else if (bus.pe_enable) begin
            bus.pe_result   <= bus.pe_result + 32'(bus.pe_a) * 32'(bus.pe_b);
            bus.pe_overflow <= (ovf_term != 0) && (pe_terms + 1 == ovf_term);
            pe_terms        <= pe_terms + 1;
        end else begin
            bus.pe_overflow <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  op_a[$];
    logic [7:0]  op_b[$];
    int          en_q[$];
    int          clr_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0, t0 = 0, rel = 0, idx = 0;
    int          valid_cyc, busy_fall, ready_hi_cnt, excl_bad, ready_bad;
    logic        hs_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        int n;
        check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) check(tag, 64'(got[i]), 64'(exp[i]));
    endtask

    // Advance one clock. A result handshake at this edge is scored before the
    // edge; per-cycle observations are recorded #1 after it.
    task automatic tick();
        logic hs, xfer;
        exp_t e;
        hs   = bus.result_valid && bus.result_ready;
        xfer = bus.operand_valid && bus.operand_ready;
        if (hs) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result", 64'(bus.result), 64'(e.res));
                check("overflow", 64'(bus.overflow), 64'(e.ovf));
            end
            hs_seen = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - t0;
        if (xfer) idx++;
        if (bus.pe_clear) clr_q.push_back(rel);
        if (bus.pe_enable) en_q.push_back(rel);
        if (bus.pe_clear && bus.pe_enable) excl_bad++;
        if (bus.operand_ready) ready_hi_cnt++;
        if (bus.operand_ready && !bus.busy) ready_bad++;
        if (bus.result_valid && valid_cyc < 0) valid_cyc = rel;
    endtask

    task automatic clear_records();
        en_q.delete();
        clr_q.delete();
        valid_cyc = -1; busy_fall = -1;
        ready_hi_cnt = 0; excl_bad = 0; ready_bad = 0;
        hs_seen = 1'b0; idx = 0;
    endtask

    // One command: start at relative cycle 0, stream op_a/op_b, optional stall
    // of stall_n cycles once stall_at pairs are accepted, ready held low for
    // rdy_delay cycles of valid, optional second start at reissue_at.
    task automatic run_cmd(input int len, input int stall_at, input int stall_n,
                           input int rdy_delay, input int reissue_at);
        exp_t        e;
        logic [31:0] held_res;
        logic        held_ovf, held_set, done, prev_hs, stalled;
        int          stall_left;
        e.res = '0;
        for (int i = 0; i < len; i++) e.res += 32'(op_a[i]) * 32'(op_b[i]);
        e.ovf = (ovf_term >= 1) && (ovf_term <= len);
        sb.push_back(e);
        clear_records();
        stall_left = stall_n;
        held_set = 1'b0; held_res = '0; held_ovf = 1'b0; done = 1'b0;
        t0 = cyc; rel = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            bus.start  = (rel == 0) || (rel == reissue_at);
            bus.length = (rel == 0) ? 16'(len) : 16'(len + 3);
            stalled = (idx == stall_at) && (stall_left > 0);
            if (stalled) stall_left--;
            bus.operand_valid = !stalled && (idx < op_a.size());
            bus.a_data = bus.operand_valid ? op_a[idx] : 8'd0;
            bus.b_data = bus.operand_valid ? op_b[idx] : 8'd0;
            bus.result_ready = (valid_cyc >= 0) && (rel >= valid_cyc + rdy_delay);
            if (bus.result_valid && held_set) begin
                check("hold_result", 64'(bus.result), 64'(held_res));
                check("hold_overflow", 64'(bus.overflow), 64'(held_ovf));
            end
            prev_hs = hs_seen;
            tick();
            if (bus.result_valid && !held_set) begin
                held_res = bus.result; held_ovf = bus.overflow; held_set = 1'b1;
            end
            if (hs_seen && !prev_hs) begin
                check("valid_drop", 64'(bus.result_valid), 0);
                busy_fall = bus.busy ? -1 : rel;
                done = 1'b1;
            end
        end
        if (!done) check("timeout", 0, 1);
        bus.start = 1'b0; bus.operand_valid = 1'b0; bus.result_ready = 1'b0;
        check("clear_enable_overlap", 64'(excl_bad), 0);
        check("ready_outside_busy", 64'(ready_bad), 0);
        tick();
    endtask

    task automatic set_ops(input logic [7:0] a[$], input logic [7:0] b[$]);
        op_a = a;
        op_b = b;
    endtask

    logic [7:0] va[$];
    logic [7:0] vb[$];
    int         vcnt;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.length = '0; bus.a_data = '0; bus.b_data = '0;
        bus.operand_valid = 1'b0; bus.result_ready = 1'b0;
        ovf_term = 0;
        clear_records();
        repeat (3) tick();
        check("reset_outputs",
              64'({bus.pe_a, bus.pe_b, bus.pe_clear, bus.pe_enable, bus.operand_ready,
                   bus.result, bus.overflow, bus.result_valid, bus.busy}), 0);
        rst_n = 1'b1;
        tick();

        // Happy path
        va = '{8'd1, 8'd2, 8'd3, 8'd4}; vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        set_ops(va, vb);
        run_cmd(4, -1, 0, 0, -1);
        check_list("happy_clear", clr_q, '{1});
        check_list("happy_enable", en_q, '{3, 4, 5, 6});
        check("happy_valid_cycle", 64'(valid_cyc), 8);
        check("happy_busy_fall", 64'(busy_fall), 9);

        // Operand stalls
        run_cmd(4, 2, 3, 0, -1);
        check_list("stall_enable", en_q, '{3, 4, 8, 9});
        check("stall_valid_cycle", 64'(valid_cyc), 11);

        // Overflow plus backpressure, then a clean command
        va = '{8'd1, 8'd2, 8'd3}; vb = '{8'd5, 8'd6, 8'd7};
        set_ops(va, vb);
        ovf_term = 2;
        run_cmd(3, -1, 0, 5, -1);
        ovf_term = 0;
        run_cmd(3, -1, 0, 0, -1);

        // Zero length
        va.delete(); vb.delete();
        set_ops(va, vb);
        run_cmd(0, -1, 0, 0, -1);
        check("zero_ready_cycles", 64'(ready_hi_cnt), 0);
        check("zero_enable_cycles", 64'(en_q.size()), 0);
        check("zero_valid_cycle", 64'(valid_cyc), 4);

        // Start while busy
        va = '{8'd1, 8'd2, 8'd3, 8'd4}; vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        set_ops(va, vb);
        run_cmd(4, -1, 0, 0, 3);
        check("busy_start_enables", 64'(en_q.size()), 4);
        check("busy_start_valid_cycle", 64'(valid_cyc), 8);

        // Reset mid-RUN after 2 of 4 transfers
        clear_records();
        t0 = cyc; rel = 0;
        bus.length = 16'd4;
        for (int k = 0; k < 20 && idx < 2; k++) begin
            bus.start = (k == 0);
            bus.operand_valid = 1'b1;
            bus.a_data = op_a[idx];
            bus.b_data = op_b[idx];
            tick();
        end
        check("reset_run_reached", 64'(idx), 2);
        bus.start = 1'b0; bus.operand_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("reset_mid_outputs",
              64'({bus.pe_a, bus.pe_b, bus.pe_clear, bus.pe_enable, bus.operand_ready,
                   bus.result, bus.overflow, bus.result_valid, bus.busy}), 0);
        rst_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.result_ready = 1'b1;
            tick();
            if (bus.result_valid) vcnt++;
        end
        bus.result_ready = 1'b0;
        check("aborted_no_result", 64'(vcnt), 0);

        va = '{8'd3, 8'd4}; vb = '{8'd2, 8'd2};
        set_ops(va, vb);
        run_cmd(2, -1, 0, 0, -1);
        check("scoreboard_drained", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
